// File: rtl/elbuf_fifo.sv
// elbuf_fifo: WIDTH-bit, DEPTH-entry elastic FIFO with req/ack handshakes on
// both sides. Every output is decoded from registers only, so there is no
// combinational path from i_1_ack to t_0_ack and no same-cycle bypass.
// Adds an occupancy count, a programmable almost-full flag and a synchronous
// clear that empties the FIFO.
module elbuf_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AFULL = DEPTH - 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] t_0_dat,
    input  logic             t_0_req,
    output logic             t_0_ack,
    output logic [WIDTH-1:0] i_1_dat,
    output logic             i_1_req,
    input  logic             i_1_ack,
    output logic [AW:0]      count,
    output logic             afull
);

    // Elaboration-time parameter sanity checks.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("elbuf_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AFULL < 1) || (AFULL > DEPTH)) begin : g_bad_afull
        $error("elbuf_fifo: AFULL must lie in 1..DEPTH");
    end

    // Occupancy constants sized to the count register.
    localparam logic [AW:0] CNT_FULL  = DEPTH[AW:0];
    localparam logic [AW:0] CNT_AFULL = AFULL[AW:0];

    // Storage is deliberately not reset; the pointers define what is valid.
    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg,  count_next;
    logic          run_reg;

    logic push;
    logic pop;

    // Output decode, purely from registered state.
    always_comb begin
        i_1_req = (count_reg != '0);
        i_1_dat = mem_reg[rd_ptr_reg];
        t_0_ack = run_reg && (count_reg != CNT_FULL);
        afull   = (count_reg >= CNT_AFULL);
        count   = count_reg;
    end

    // Handshake decode and next-state for pointers and occupancy; clear wins.
    always_comb begin
        push        = t_0_req && t_0_ack;
        pop         = i_1_req && i_1_ack;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            // Pointers wrap naturally at AW bits.
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + (AW + 1)'(1);
                2'b01:   count_next = count_reg - (AW + 1)'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and occupancy registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Run flag holds off t_0_ack until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // Data write on an accepted beat; a beat accepted while clearing is dropped.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_reg[wr_ptr_reg] <= t_0_dat;
        end
    end

endmodule

// File: tb/tb_elbuf_fifo.sv
// tb_elbuf_fifo: directed and randomized checks of elbuf_fifo (WIDTH=32,
// DEPTH=4, AFULL=3). Accepted input beats go into a scoreboard queue; a
// separate monitor pops and compares on every output transfer, and a status
// checker compares count/flags against the queue occupancy every cycle.
module tb_elbuf_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic             clk     = 1'b0;
    logic             reset_n = 1'b0;
    logic             clr     = 1'b0;
    logic [WIDTH-1:0] t_0_dat = '0;
    logic             t_0_req = 1'b0;
    logic             t_0_ack;
    logic [WIDTH-1:0] i_1_dat;
    logic             i_1_req;
    logic             i_1_ack = 1'b0;
    logic [2:0]       count;
    logic             afull;

    int n_tests  = 0;
    int n_fail   = 0;
    int rx_count = 0;
    logic run_m  = 1'b0;

    logic [WIDTH-1:0] sb [$];

    elbuf_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AFULL (AFULL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .t_0_dat (t_0_dat),
        .t_0_req (t_0_req),
        .t_0_ack (t_0_ack),
        .i_1_dat (i_1_dat),
        .i_1_req (i_1_req),
        .i_1_ack (i_1_ack),
        .count   (count),
        .afull   (afull)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard input: record accepted beats (after the monitor has run).
    always @(negedge clk) begin
        #1;
        if (!reset_n || clr) begin
            sb.delete();
        end else if (t_0_req && t_0_ack) begin
            sb.push_back(t_0_dat);
        end
    end

    // Monitor: every output transfer must deliver the oldest outstanding beat.
    always @(negedge clk) begin
        if (reset_n && !clr && i_1_req && i_1_ack) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected: got %0h expected no beat at %0t", i_1_dat, $time);
            end else begin
                check("out_data", i_1_dat, sb.pop_front());
            end
            rx_count++;
        end
    end

    // Status checker: flags and count against the reference occupancy.
    always @(posedge clk) begin
        run_m = reset_n;
        #1;
        check("st_count", count, sb.size());
        check("st_req", i_1_req, sb.size() != 0);
        check("st_ack", t_0_ack, run_m && (sb.size() < DEPTH));
        check("st_afull", afull, sb.size() >= AFULL);
        check("st_bound", count <= DEPTH, 1);
        if (i_1_req && sb.size() != 0) begin
            check("st_head", i_1_dat, sb[0]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rx_base;
        int cyc;
        logic acc;
        logic hold;

        // Startup
        repeat (3) cycle();
        check("rst_count", count, 0);
        check("rst_req", i_1_req, 0);
        check("rst_ack", t_0_ack, 0);
        check("rst_afull", afull, 0);
        reset_n = 1'b1;
        #1;
        check("run_ack_low", t_0_ack, 0);
        cycle();
        check("run_ack_high", t_0_ack, 1);

        // Fill
        i_1_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t_0_req = 1'b1;
            t_0_dat = 32'hA0 + i;
            cycle();
            check("fill_count", count, i + 1);
            check("fill_afull", afull, (i + 1) >= 3);
        end
        check("full_ack", t_0_ack, 0);
        t_0_dat = 32'hA4;
        cycle();
        check("full_hold_count", count, 4);
        check("full_hold_ack", t_0_ack, 0);

        // Drain
        t_0_req = 1'b0;
        i_1_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_req", i_1_req, 1);
            check("drain_dat", i_1_dat, 32'hA0 + i);
            cycle();
            if (i == 0) check("ack_after_pop", t_0_ack, 1);
        end
        check("drain_empty_req", i_1_req, 0);
        check("drain_empty_count", count, 0);
        i_1_ack = 1'b0;

        // Simultaneous push/pop at count=2
        t_0_req = 1'b1;
        t_0_dat = 32'hB0;
        cycle();
        t_0_dat = 32'hB1;
        cycle();
        t_0_dat = 32'hB2;
        i_1_ack = 1'b1;
        check("sim2_head", i_1_dat, 32'hB0);
        cycle();
        check("sim2_count", count, 2);
        check("sim2_head2", i_1_dat, 32'hB1);
        t_0_req = 1'b0;
        cycle();
        check("sim2_tail", i_1_dat, 32'hB2);
        cycle();
        check("sim2_empty", count, 0);
        i_1_ack = 1'b0;

        // Simultaneous push/pop at count=1
        t_0_req = 1'b1;
        t_0_dat = 32'hC0;
        cycle();
        t_0_dat = 32'hC1;
        i_1_ack = 1'b1;
        cycle();
        check("sim1_count", count, 1);
        check("sim1_head", i_1_dat, 32'hC1);
        t_0_req = 1'b0;
        cycle();
        check("sim1_empty", count, 0);
        i_1_ack = 1'b0;

        // Clear with push and pop on the same edge
        t_0_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t_0_dat = 32'hD0 + i;
            cycle();
        end
        check("clr_pre_count", count, 3);
        clr = 1'b1;
        t_0_dat = 32'hD3;
        i_1_ack = 1'b1;
        check("clr_ack", t_0_ack, 1);
        cycle();
        clr = 1'b0;
        check("clr_count", count, 0);
        check("clr_req", i_1_req, 0);
        t_0_dat = 32'hE0;
        i_1_ack = 1'b0;
        cycle();
        t_0_req = 1'b0;
        check("clr_next_count", count, 1);
        check("clr_next_head", i_1_dat, 32'hE0);
        i_1_ack = 1'b1;
        cycle();
        check("clr_drained", count, 0);
        i_1_ack = 1'b0;

        // Randomized streaming with wrap
        sent    = 0;
        rx_base = rx_count;
        cyc     = 0;
        hold    = 1'b0;
        while ((rx_count - rx_base) < 1000 && cyc < 20000) begin
            if (!hold) begin
                t_0_req = (sent < 1000) && ($urandom_range(1, 0) == 1);
                t_0_dat = 32'h5000_0000 + sent;
            end
            i_1_ack = ($urandom_range(1, 0) == 1);
            acc = t_0_req && t_0_ack;
            cycle();
            cyc++;
            if (acc) sent++;
            hold = t_0_req && !acc;
        end
        t_0_req = 1'b0;
        i_1_ack = 1'b0;
        check("stream_rx", rx_count - rx_base, 1000);
        check("stream_sent", sent, 1000);
        check("stream_empty", count, 0);

        // Mid-stream reset with count=3 and a request pending
        t_0_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t_0_dat = 32'hF0 + i;
            cycle();
        end
        t_0_dat = 32'hF3;
        check("mid_pre_count", count, 3);
        reset_n = 1'b0;
        #1;
        check("mid_rst_count", count, 0);
        check("mid_rst_req", i_1_req, 0);
        check("mid_rst_ack", t_0_ack, 0);
        check("mid_rst_afull", afull, 0);
        t_0_req = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
        #1;
        check("mid_rel_ack_low", t_0_ack, 0);
        cycle();
        check("mid_rel_ack_high", t_0_ack, 1);
        check("mid_rel_count", count, 0);

        cycle();
        cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
